// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store request controller.
//   state_t        : controller FSM states
//   SZ_*           : access size encodings (byte/half/word/double)
//   MASK_*         : byte-enable patterns for an access at lane 0
//   base_mask()    : size -> unshifted byte-enable pattern
//   is_misaligned(): natural-alignment test on the low address bits
package lsu_pkg;

  localparam int unsigned LSU_DW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  function automatic logic [7:0] base_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return MASK_B;
      SZ_H:    return MASK_H;
      SZ_W:    return MASK_W;
      default: return MASK_D;
    endcase
  endfunction

  // Byte accesses can never be misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo);
    case (size)
      SZ_H:    return lo[0];
      SZ_W:    return |lo[1:0];
      SZ_D:    return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-result extraction.
//   rdata       : doubleword returned by memory
//   off         : byte offset of the access inside the doubleword
//   size        : access size (SZ_B/SZ_H/SZ_W/SZ_D)
//   is_unsigned : zero-extend instead of sign-extend (ignored for SZ_D)
//   result      : right-aligned, extended load value
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [LSU_DW-1:0] rdata,
  input  logic [2:0]        off,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [LSU_DW-1:0] result
);

  logic [LSU_DW-1:0] raw;

  // Bytes shifted past the top of the doubleword are simply lost.
  always_comb begin
    raw    = rdata >> {off, 3'b000};
    result = raw;
    case (size)
      SZ_B:    result = is_unsigned ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      SZ_H:    result = is_unsigned ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      SZ_W:    result = is_unsigned ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/lsu_req_ctrl.sv
// Load/store request controller feeding the DPI-backed memory stage.
// Accepts one op per in_valid/in_ready handshake, issues exactly one
// single-cycle read or write strobe with a doubleword-aligned address,
// byte mask and lane-shifted data, then returns the extended load result
// on an out_valid/out_ready handshake.
//   clock, reset             : clock, synchronous active-high reset
//   in_valid/in_ready        : op request handshake
//   in_is_store/in_size/in_unsigned/in_addr/in_wdata : op fields
//   mem_raddr/mem_waddr      : aligned addresses (low 3 bits zero)
//   mem_wdata/mem_wmask      : lane-shifted store data and byte enables
//   mem_read_en/mem_write_en : one-cycle strobes, high only in REQ
//   mem_rdata                : memory read data, combinational in REQ
//   out_valid/out_ready      : result handshake
//   out_rdata/out_err        : extended load data / misaligned flag
// Build option: define LSU_MISALIGN_CHECK_EN to reject misaligned ops
// with out_err=1 and no memory access; otherwise they proceed with the
// truncated mask/shift.
module lsu_req_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  output logic              mem_read_en,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_err
);

  state_t            state;
  logic              op_store;
  logic [1:0]        op_size;
  logic              op_unsigned;
  logic [2:0]        op_off;

  logic [ADDR_W-1:0] addr_dw_c;
  logic [7:0]        wmask_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] load_data_c;
  logic              misalign_c;

  // Request-side lane placement, computed from the op being accepted.
  assign addr_dw_c = {in_addr[ADDR_W-1:3], 3'b000};
  assign wmask_c   = 8'(base_mask(in_size) << in_addr[2:0]);
  assign wdata_c   = in_wdata << {in_addr[2:0], 3'b000};

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_c = is_misaligned(in_size, in_addr[2:0]);
`else
  assign misalign_c = 1'b0;
`endif

  // Extraction runs on the registered op fields against live mem_rdata.
  lsu_load_align u_load_align (
    .rdata       (mem_rdata),
    .off         (op_off),
    .size        (op_size),
    .is_unsigned (op_unsigned),
    .result      (load_data_c)
  );

  // Controller FSM; every output is a flop updated here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      op_store     <= 1'b0;
      op_size      <= SZ_B;
      op_unsigned  <= 1'b0;
      op_off       <= 3'd0;
      in_ready     <= 1'b1;
      mem_raddr    <= '0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      mem_wmask    <= 8'h00;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      out_valid    <= 1'b0;
      out_rdata    <= '0;
      out_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_store    <= in_is_store;
            op_size     <= in_size;
            op_unsigned <= in_unsigned;
            op_off      <= in_addr[2:0];
            in_ready    <= 1'b0;
            if (misalign_c) begin
              // Rejected op: no memory access at all.
              state     <= RESP;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_rdata <= '0;
            end else begin
              state        <= REQ;
              mem_raddr    <= addr_dw_c;
              mem_waddr    <= addr_dw_c;
              mem_wdata    <= wdata_c;
              mem_wmask    <= in_is_store ? wmask_c : 8'h00;
              mem_read_en  <= !in_is_store;
              mem_write_en <= in_is_store;
            end
          end
        end
        REQ: begin
          // Strobes drop after one cycle so a store hits DPI exactly once.
          mem_read_en  <= 1'b0;
          mem_write_en <= 1'b0;
          out_valid    <= 1'b1;
          out_err      <= 1'b0;
          out_rdata    <= op_store ? '0 : load_data_c;
          state        <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
